// File: rtl/mioc_flop_drv_if.sv
// Command/response handshake between the register/control logic and the MIOC flop driver.
// The master side issues set/clear commands; the slave side (the driver) answers with pass/fail.
interface mioc_flop_drv_if #(
  parameter int ERR_W = 8
);
  logic             cmd_valid;
  logic             cmd_op;
  logic             cmd_ready;
  logic             rsp_valid;
  logic             rsp_ok;
  logic             rsp_q;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, rsp_valid, rsp_ok, rsp_q, err_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, rsp_valid, rsp_ok, rsp_q, err_cnt
  );
endinterface

// File: rtl/mioc_flop_drv.sv
// Initiator for the MIOC set/reset flop: pulses the flop control lines for a set or clear,
// waits for the flop to settle, samples q/qbar through a synchronizer and reports pass/fail.
module mioc_flop_drv #(
  parameter int PULSE_W  = 4,
  parameter int SETTLE_W = 3,
  parameter int ERR_W    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mioc_flop_drv_if.slave bus,
  output logic           o_flop_in1,
  output logic           o_flop_in2,
  output logic           o_flop_in3,
  output logic           o_flop_in4,
  input  logic           i_flop_q,
  input  logic           i_flop_qbar
);

  localparam int CNT_MAX = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic             r_cmdReady;
  logic             r_rspValid;
  logic             r_rspOk;
  logic             r_rspQ;
  logic [ERR_W-1:0] r_errCnt;
  logic             r_in1;
  logic             r_in2;
  logic             r_in3;
  logic             r_in4;
  logic             r_qMeta;
  logic             r_qSync;
  logic             r_qbarMeta;
  logic             r_qbarSync;
  logic             w_rspOk;

  // The flop outputs are asynchronous to clk; only the second stage is ever read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qMeta    <= 1'b0;
      r_qSync    <= 1'b0;
      r_qbarMeta <= 1'b0;
      r_qbarSync <= 1'b0;
    end else begin
      r_qMeta    <= i_flop_q;
      r_qSync    <= r_qMeta;
      r_qbarMeta <= i_flop_qbar;
      r_qbarSync <= r_qbarMeta;
    end
  end

  assign w_rspOk = (r_qSync == r_op) && (r_qSync != r_qbarSync);

  // Lines go active on the accepting edge, so they stay up exactly PULSE_W cycles.
  // in3 is always written alongside in2 with the inverse value, keeping it glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= 1'b0;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_rspOk    <= 1'b0;
      r_rspQ     <= 1'b0;
      r_errCnt   <= '0;
      r_in1      <= 1'b0;
      r_in2      <= 1'b0;
      r_in3      <= 1'b1;
      r_in4      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rspValid <= 1'b0;
          if (bus.cmd_valid) begin
            r_op       <= bus.cmd_op;
            r_cnt      <= PULSE_LOAD;
            r_state    <= ST_DRIVE;
            r_cmdReady <= 1'b0;
            r_in4      <= bus.cmd_op;
            r_in1      <= ~bus.cmd_op;
            r_in2      <= ~bus.cmd_op;
            r_in3      <= bus.cmd_op;
          end
        end
        ST_DRIVE: begin
          if (r_cnt == '0) begin
            r_in1   <= 1'b0;
            r_in2   <= 1'b0;
            r_in3   <= 1'b1;
            r_in4   <= 1'b0;
            r_cnt   <= SETTLE_LOAD;
            r_state <= ST_SETTLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state    <= ST_CHECK;
            r_rspValid <= 1'b1;
            r_rspQ     <= r_qSync;
            r_rspOk    <= w_rspOk;
            if (!w_rspOk && (r_errCnt != '1)) begin
              r_errCnt <= r_errCnt + ERR_ONE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_CHECK: begin
          r_rspValid <= 1'b0;
          r_cmdReady <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_rspValid <= 1'b0;
          r_cmdReady <= 1'b1;
          r_in1      <= 1'b0;
          r_in2      <= 1'b0;
          r_in3      <= 1'b1;
          r_in4      <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmdReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_ok    = r_rspOk;
  assign bus.rsp_q     = r_rspQ;
  assign bus.err_cnt   = r_errCnt;
  assign o_flop_in1    = r_in1;
  assign o_flop_in2    = r_in2;
  assign o_flop_in3    = r_in3;
  assign o_flop_in4    = r_in4;

endmodule

// File: tb/tb_mioc_flop_drv.sv
// Bench for mioc_flop_drv: a behavioural flop plus a command-level scoreboard predicting
// line activity, response timing, pass/fail and error counts for two driver instances.
module tb_mioc_flop_drv;

  localparam int PULSE_W  = 4;
  localparam int SETTLE_W = 3;
  localparam int LAT      = PULSE_W + SETTLE_W + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mioc_flop_drv_if #(.ERR_W(8)) busA ();
  mioc_flop_drv_if #(.ERR_W(2)) busB ();

  logic aIn1, aIn2, aIn3, aIn4;
  logic bIn1, bIn2, bIn3, bIn4;
  logic flopState = 1'b0;
  logic faultOn = 1'b0;
  logic faultQ = 1'b0;
  logic faultQbar = 1'b0;
  logic aQ, aQbar;

  int checkCount = 0;
  int failCount = 0;

  // Instance A sees a healthy (or deliberately faulted) flop; instance B has its q/qbar
  // tied low, so every one of its responses fails and its 2-bit counter must saturate.
  mioc_flop_drv #(.PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W), .ERR_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .bus(busA),
    .o_flop_in1(aIn1), .o_flop_in2(aIn2), .o_flop_in3(aIn3), .o_flop_in4(aIn4),
    .i_flop_q(aQ), .i_flop_qbar(aQbar)
  );

  mioc_flop_drv #(.PULSE_W(PULSE_W), .SETTLE_W(SETTLE_W), .ERR_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(busB),
    .o_flop_in1(bIn1), .o_flop_in2(bIn2), .o_flop_in3(bIn3), .o_flop_in4(bIn4),
    .i_flop_q(1'b0), .i_flop_qbar(1'b0)
  );

  always #5 clk = ~clk;

  always @(posedge aIn4 or posedge aIn1) flopState <= aIn4;

  assign aQ    = faultOn ? faultQ : flopState;
  assign aQbar = faultOn ? faultQbar : ~flopState;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Scoreboard state for the single outstanding command.
  int   cyc = 0;
  int   age;
  logic haveCur = 1'b0;
  int   curAcc;
  logic curOp, curQ, curQbar;
  logic lastQ, lastOk, expOk;
  int   errsA = 0;
  int   errsB = 0;
  logic busy = 1'b0;
  logic busyPrev = 1'b0;
  int   lastAcc = 0;
  logic actSet, actClr;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      haveCur  = 1'b0;
      errsA    = 0;
      errsB    = 0;
      busyPrev = 1'b0;
    end else begin
      age    = cyc - curAcc;
      actSet = haveCur && (age >= 1) && (age <= PULSE_W) && curOp;
      actClr = haveCur && (age >= 1) && (age <= PULSE_W) && !curOp;
      checkOutput("linesA", {aIn1, aIn2, aIn3, aIn4}, {actClr, actClr, !actClr, actSet});
      checkOutput("linesB", {bIn1, bIn2, bIn3, bIn4}, {actClr, actClr, !actClr, actSet});
      checkOutput("readyA", busA.cmd_ready, !(haveCur && age <= LAT));
      checkOutput("readyB", busB.cmd_ready, !(haveCur && age <= LAT));
      checkOutput("rspValidA", busA.rsp_valid, haveCur && age == LAT);
      checkOutput("rspValidB", busB.rsp_valid, haveCur && age == LAT);
      if (haveCur && age == LAT) begin
        expOk = (curQ == curOp) && (curQ != curQbar);
        if (!expOk && errsA < 255) errsA++;
        if (errsB < 3) errsB++;
        checkOutput("rspQA", busA.rsp_q, curQ);
        checkOutput("rspOkA", busA.rsp_ok, expOk);
        checkOutput("errCntA", busA.err_cnt, errsA);
        checkOutput("rspQB", busB.rsp_q, 1'b0);
        checkOutput("rspOkB", busB.rsp_ok, 1'b0);
        checkOutput("errCntB", busB.err_cnt, errsB);
        lastQ  = curQ;
        lastOk = expOk;
      end
      if (haveCur && age == LAT + 1) begin
        checkOutput("holdQA", busA.rsp_q, lastQ);
        checkOutput("holdOkA", busA.rsp_ok, lastOk);
        haveCur = 1'b0;
      end
      if (busA.cmd_ready && busA.cmd_valid) begin
        if (haveCur) checkOutput("overlapAccept", 1, 0);
        if (busy && busyPrev) checkOutput("busySpacing", cyc - lastAcc, LAT + 1);
        busyPrev = busy;
        lastAcc  = cyc;
        haveCur  = 1'b1;
        curAcc   = cyc;
        curOp    = busA.cmd_op;
        curQ     = faultOn ? faultQ : busA.cmd_op;
        curQbar  = faultOn ? faultQbar : ~busA.cmd_op;
      end
    end
  end

  task automatic driveCmd(input logic valid, input logic op);
    busA.cmd_valid = valid;
    busA.cmd_op    = op;
    busB.cmd_valid = valid;
    busB.cmd_op    = op;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (haveCur && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (haveCur) checkOutput("idleTimeout", 0, 1);
  endtask

  // Present a command until it is accepted, then scramble cmd_op to prove it was latched.
  task automatic waitAccept(input logic op);
    logic accepted = 1'b0;
    driveCmd(1'b1, op);
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (busA.cmd_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    if (!accepted) checkOutput("acceptTimeout", 0, 1);
    driveCmd(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic applyStimulus(input logic op, input logic fOn, input logic fQ, input logic fQbar);
    faultOn   = fOn;
    faultQ    = fQ;
    faultQbar = fQbar;
    waitAccept(op);
    waitIdle();
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  initial begin
    driveCmd(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReadyA", busA.cmd_ready, 1'b1);
    checkOutput("rstRspA", {busA.rsp_valid, busA.rsp_ok, busA.rsp_q}, 3'b000);
    checkOutput("rstErrA", busA.err_cnt, 0);
    checkOutput("rstLinesA", {aIn1, aIn2, aIn3, aIn4}, 4'b0010);
    checkOutput("rstErrB", busB.err_cnt, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("stuckErr1", busA.err_cnt, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("stuckErr2", busA.err_cnt, 2);
    faultOn = 1'b0;

    busy = 1'b1;
    driveCmd(1'b1, 1'b0);
    for (int i = 0; i < 45; i++) begin
      busA.cmd_op = 1'($urandom_range(0, 1));
      busB.cmd_op = busA.cmd_op;
      @(posedge clk); #1;
    end
    driveCmd(1'b0, 1'b0);
    busy = 1'b0;
    waitIdle();

    waitAccept(1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstLinesA", {aIn1, aIn2, aIn3, aIn4}, 4'b0010);
    checkOutput("midRstLinesB", {bIn1, bIn2, bIn3, bIn4}, 4'b0010);
    checkOutput("midRstRsp", busA.rsp_valid, 1'b0);
    checkOutput("midRstReady", busA.cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstReady", busA.cmd_ready, 1'b1);
    checkOutput("postRstErrA", busA.err_cnt, 0);
    checkOutput("postRstErrB", busB.err_cnt, 0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
